// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: one bit per cycle,
// fixed latency, stalls the front of the pipe while it works.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [9:0]      funct_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o
);

    localparam int CNT_W = $clog2(XLEN);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic            negRes_q, negRes_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rdOut_q, rdOut_d;

    logic            start;
    logic            isDivIn;
    logic            signA, signB;
    logic            aNeg, bNeg;
    logic            negStart;
    logic [XLEN-1:0] magA, magB;

    logic [XLEN:0]   mulSum;
    logic [XLEN:0]   divShift;
    logic [XLEN-1:0] divDiff;
    logic            divFits;

    logic [2*XLEN-1:0] prod, prodAdj;
    logic [XLEN-1:0]   divRaw, divAdj;
    logic [XLEN-1:0]   finalResult;

    assign start = valid_i && (funct_i[9:3] == 7'b0000001) && (state_q == IDLE);

    // Signed ops run on magnitudes; negStart records whether the final
    // value must be negated. A zero divisor never flips the quotient sign,
    // so DIV by zero still yields all ones.
    always_comb begin
        isDivIn  = funct_i[2];
        signA    = isDivIn ? ~funct_i[0] : (funct_i[1:0] == 2'b01 || funct_i[1:0] == 2'b10);
        signB    = isDivIn ? ~funct_i[0] : (funct_i[1:0] == 2'b01);
        aNeg     = signA & rs1_data_i[XLEN-1];
        bNeg     = signB & rs2_data_i[XLEN-1];
        magA     = aNeg ? -rs1_data_i : rs1_data_i;
        magB     = bNeg ? -rs2_data_i : rs2_data_i;
        negStart = 1'b0;
        if (!isDivIn) begin
            negStart = aNeg ^ bNeg;
        end else if (!funct_i[1]) begin
            negStart = (aNeg ^ bNeg) && (rs2_data_i != '0);
        end else begin
            negStart = aNeg;
        end
    end

    // Multiply: {hi, lo} shifts right, adding the multiplicand when lo[0] is set.
    // Divide: restoring step, remainder in hi, quotient shifts into lo.
    always_comb begin
        mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        divShift = {hi_q, lo_q[XLEN-1]};
        divFits  = divShift >= {1'b0, opb_q};
        divDiff  = divShift[XLEN-1:0] - opb_q;
    end

    always_comb begin
        prod    = {hi_q, lo_q};
        prodAdj = negRes_q ? -prod : prod;
        divRaw  = op_q[1] ? hi_q : lo_q;
        divAdj  = negRes_q ? -divRaw : divRaw;
        if (op_q[2]) begin
            finalResult = divAdj;
        end else if (op_q[1:0] == 2'b00) begin
            finalResult = prodAdj[XLEN-1:0];
        end else begin
            finalResult = prodAdj[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        rd_d     = rd_q;
        negRes_d = negRes_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        result_d = result_q;
        rdOut_d  = rdOut_q;
        case (state_q)
            IDLE: begin
                if (start && !flush_i) begin
                    state_d  = CALC;
                    count_d  = '0;
                    op_d     = funct_i[2:0];
                    rd_d     = rd_addr_i;
                    negRes_d = negStart;
                    hi_d     = '0;
                    lo_d     = isDivIn ? magA : magB;
                    opb_d    = isDivIn ? magB : magA;
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                    if (op_q[2]) begin
                        hi_d = divFits ? divDiff : divShift[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], divFits};
                    end else begin
                        hi_d = mulSum[XLEN:1];
                        lo_d = {mulSum[0], lo_q[XLEN-1:1]};
                    end
                    if (count_q == CNT_W'(XLEN-1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d  = IDLE;
                result_d = finalResult;
                rdOut_d  = rd_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            count_q  <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            negRes_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            result_q <= '0;
            rdOut_q  <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            negRes_q <= negRes_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            rdOut_q  <= rdOut_d;
        end
    end

    // The DONE cycle shows the fresh result directly; afterwards the held copy.
    assign busy_o    = start || (state_q == CALC);
    assign done_o    = (state_q == DONE);
    assign result_o  = done_o ? finalResult : result_q;
    assign rd_addr_o = done_o ? rd_q : rdOut_q;

endmodule
